// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_align_unit
// Description : Load unit issuing word-aligned reads, merging a two-word
//               access when an operand straddles a word boundary, then
//               sign/zero-extending the addressed byte/half/word/double.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align_unit #(
    parameter int XLEN          = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_fault
);
    localparam int c_nbytes = XLEN / 8;
    localparam int c_offw   = $clog2(c_nbytes);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_fault_q, rsp_fault_d;

    logic [XLEN-1:0] w_base;
    logic            w_spans;
    logic            w_req_bad;

    function automatic logic f_illegal(input logic [2:0] f);
        return (f == 3'b111) || ((XLEN == 32) && ((f == 3'b011) || (f == 3'b110)));
    endfunction

    function automatic logic f_spans(input logic [c_offw-1:0] off, input logic [1:0] sz);
        logic [4:0] sum;
        sum = 5'(off) + (5'd1 << sz);
        return sum > 5'(c_nbytes);
    endfunction

    // Mask selects the kept bytes; the complement is filled with the sign bit.
    function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] hi,
                                                  input logic [XLEN-1:0] lo,
                                                  input logic [c_offw-1:0] off,
                                                  input logic [2:0] f);
        logic [XLEN-1:0] w;
        logic [XLEN-1:0] mask;
        logic            top;
        w = XLEN'({hi, lo} >> {off, 3'b000});
        case (f[1:0])
            2'd0:    begin mask = XLEN'(8'hFF);         top = w[7];      end
            2'd1:    begin mask = XLEN'(16'hFFFF);      top = w[15];     end
            2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); top = w[31];     end
            default: begin mask = '1;                   top = w[XLEN-1]; end
        endcase
        return (w & mask) | ((!f[2] && top) ? ~mask : '0);
    endfunction

    assign w_base    = {addr_q[XLEN-1:c_offw], c_offw'(0)};
    assign w_spans   = f_spans(addr_q[c_offw-1:0], funct3_q[1:0]);
    assign w_req_bad = f_illegal(req_funct3) ||
                       (!MISALIGNED_EN && f_spans(req_addr[c_offw-1:0], req_funct3[1:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            funct3_q    <= '0;
            addr_q      <= '0;
            lo_q        <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        lo_d          = lo_q;
        rsp_data_d    = rsp_data_q;
        rsp_fault_d   = rsp_fault_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    if (w_req_bad) begin
                        rsp_data_d  = '0;
                        rsp_fault_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = w_base;
                if (mem_req_ready) state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem_rsp_valid) begin
                    lo_d = mem_rsp_data;
                    if (w_spans) begin
                        state_d = S_REQ1;
                    end else begin
                        rsp_data_d  = f_extract('0, mem_rsp_data, addr_q[c_offw-1:0], funct3_q);
                        rsp_fault_d = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end
            S_REQ1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = w_base + XLEN'(c_nbytes);
                if (mem_req_ready) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rsp_valid) begin
                    rsp_data_d  = f_extract(mem_rsp_data, lo_q, addr_q[c_offw-1:0], funct3_q);
                    rsp_fault_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_valid = (state_q == S_DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_align_unit
// Description : Scoreboard bench for load_align_unit across three builds:
//               32-bit with split support, 32-bit faulting, and 64-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_align_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid [3] = '{1'b0, 1'b0, 1'b0};
    logic [2:0]  f3        [3] = '{3'd0, 3'd0, 3'd0};
    logic [63:0] req_addr  [3] = '{64'd0, 64'd0, 64'd0};
    logic        mrr       [3] = '{1'b1, 1'b1, 1'b1};
    logic        auto_v    [3] = '{1'b0, 1'b0, 1'b0};
    logic        force_v   [3] = '{1'b0, 1'b0, 1'b0};
    logic        auto_en   [3] = '{1'b1, 1'b1, 1'b1};
    logic [63:0] rsp_d     [3] = '{64'd0, 64'd0, 64'd0};
    int          stall_cfg [3] = '{0, 0, 0};
    int          stall_cnt [3] = '{0, 0, 0};
    logic        stalled   [3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] stall_adr [3] = '{64'd0, 64'd0, 64'd0};
    int          bad_stab  [3] = '{0, 0, 0};
    int          n_log     [3] = '{0, 0, 0};
    logic [63:0] addr_log  [3][64];

    wire         rr  [3];
    wire         mrv [3];
    wire         rv  [3];
    wire         rf  [3];
    wire [31:0]  mra0, rd0, mra1, rd1;
    wire [63:0]  mra2, rd2;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        logic [63:0] data;
        logic        fault;
        int          lat;
        int          na;
        logic [63:0] a0;
        logic [63:0] a1;
    } exp_t;
    exp_t sb[$];

    load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b1)) u_d32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(rr[0]), .req_funct3(f3[0]), .req_addr(req_addr[0][31:0]),
        .mem_req_valid(mrv[0]), .mem_req_ready(mrr[0]), .mem_req_addr(mra0),
        .mem_rsp_valid(auto_v[0] | force_v[0]), .mem_rsp_data(rsp_d[0][31:0]),
        .rsp_valid(rv[0]), .rsp_data(rd0), .rsp_fault(rf[0])
    );
    load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b0)) u_d32n (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(rr[1]), .req_funct3(f3[1]), .req_addr(req_addr[1][31:0]),
        .mem_req_valid(mrv[1]), .mem_req_ready(mrr[1]), .mem_req_addr(mra1),
        .mem_rsp_valid(auto_v[1] | force_v[1]), .mem_rsp_data(rsp_d[1][31:0]),
        .rsp_valid(rv[1]), .rsp_data(rd1), .rsp_fault(rf[1])
    );
    load_align_unit #(.XLEN(64), .MISALIGNED_EN(1'b1)) u_d64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(rr[2]), .req_funct3(f3[2]), .req_addr(req_addr[2]),
        .mem_req_valid(mrv[2]), .mem_req_ready(mrr[2]), .mem_req_addr(mra2),
        .mem_rsp_valid(auto_v[2] | force_v[2]), .mem_rsp_data(rsp_d[2]),
        .rsp_valid(rv[2]), .rsp_data(rd2), .rsp_fault(rf[2])
    );

    function automatic logic [63:0] f_mra(input int g);
        case (g)
            0:       return {32'h0, mra0};
            1:       return {32'h0, mra1};
            default: return mra2;
        endcase
    endfunction

    function automatic logic [63:0] f_rd(input int g);
        case (g)
            0:       return {32'h0, rd0};
            1:       return {32'h0, rd1};
            default: return rd2;
        endcase
    endfunction

    function automatic logic [63:0] mem_word(input int g, input logic [63:0] a);
        if (g == 2) begin
            if (a == 64'h0) return 64'h0123_4567_89AB_CDEF;
            if (a == 64'h8) return 64'hFEDC_BA98_7654_3210;
            return a ^ 64'h5A5A_5A5A_5A5A_5A5A;
        end
        case (a[31:0])
            32'h0000_0100: return 64'h3456_789A;
            32'h0000_0104: return 64'hDEAD_BEEF;
            32'hFFFF_FFFC: return 64'h1122_3344;
            32'h0000_0000: return 64'h5566_7788;
            default:       return {32'h0, a[31:0] ^ 32'h5A5A_5A5A};
        endcase
    endfunction

    // Memory model: optional stall before accepting, reply the cycle after the handshake.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mrv[g] && stall_cnt[g] < stall_cfg[g]) begin
                mrr[g] = 1'b0;
                stall_cnt[g]++;
            end else begin
                mrr[g] = 1'b1;
                if (!mrv[g]) stall_cnt[g] = 0;
            end
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mrv[g] && mrr[g]) begin
                if (stalled[g] && stall_adr[g] != f_mra(g)) bad_stab[g]++;
                stalled[g] = 1'b0;
                if (n_log[g] < 64) addr_log[g][n_log[g]] = f_mra(g);
                n_log[g]++;
                auto_v[g] <= auto_en[g];
                rsp_d[g]  <= mem_word(g, f_mra(g));
            end else begin
                if (mrv[g]) begin
                    if (stalled[g] && stall_adr[g] != f_mra(g)) bad_stab[g]++;
                    stalled[g]   = 1'b1;
                    stall_adr[g] = f_mra(g);
                end else if (stalled[g]) begin
                    bad_stab[g]++;
                    stalled[g] = 1'b0;
                end
                auto_v[g] <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic do_load(input string nm, input int g, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] d, input logic flt, input int lat, input int na,
                           input logic [63:0] a0, input logic [63:0] a1, input int stall);
        exp_t e;
        int   base;
        int   badb;
        int   n;
        bit   got;
        e.data = d; e.fault = flt; e.lat = lat; e.na = na; e.a0 = a0; e.a1 = a1;
        sb.push_back(e);
        stall_cfg[g] = stall;
        base = n_log[g];
        badb = bad_stab[g];
        @(negedge clk);
        req_valid[g] = 1'b1;
        f3[g]        = op;
        req_addr[g]  = a;
        chk({nm, ".ready"}, 64'(rr[g]), 64'd1);
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            req_valid[g] = 1'b0;
            n++;
            if (rv[g]) got = 1'b1;
            else if (n == 1) chk({nm, ".busy"}, 64'(rr[g]), 64'd0);
        end
        e = sb.pop_front();
        chk({nm, ".lat"}, got ? 64'(n) : 64'hFFFF, 64'(e.lat));
        chk({nm, ".data"}, f_rd(g), e.data);
        chk({nm, ".fault"}, 64'(rf[g]), 64'(e.fault));
        chk({nm, ".nmem"}, 64'(n_log[g] - base), 64'(e.na));
        if (e.na > 0) chk({nm, ".addr0"}, addr_log[g][base], e.a0);
        if (e.na > 1) chk({nm, ".addr1"}, addr_log[g][base + 1], e.a1);
        chk({nm, ".stable"}, 64'(bad_stab[g] - badb), 64'd0);
        @(negedge clk);
        chk({nm, ".pulse"}, 64'(rv[g]), 64'd0);
        chk({nm, ".hold"}, f_rd(g), e.data);
        stall_cfg[g] = 0;
    endtask

    task automatic watch_no_rsp(input string nm, input int g, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            force_v[g] = (i == 0);
            if (rv[g]) seen++;
        end
        force_v[g] = 1'b0;
        chk({nm, ".norsp"}, 64'(seen), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst.ready", 64'(rr[g]), 64'd1);
            chk("rst.mvalid", 64'(mrv[g]), 64'd0);
            chk("rst.rvalid", 64'(rv[g]), 64'd0);
            chk("rst.fault", 64'(rf[g]), 64'd0);
            chk("rst.data", f_rd(g), 64'd0);
            chk("rst.maddr", f_mra(g), 64'd0);
        end
        rst = 1'b0;

        // 32-bit aligned and in-word accesses
        do_load("lb100",  0, 3'b000, 64'h100, 64'hFFFF_FF9A, 1'b0, 3, 1, 64'h100, 64'h0, 0);
        do_load("lbu103", 0, 3'b100, 64'h103, 64'h0000_0034, 1'b0, 3, 1, 64'h100, 64'h0, 0);
        do_load("lh102",  0, 3'b001, 64'h102, 64'h0000_3456, 1'b0, 3, 1, 64'h100, 64'h0, 0);
        do_load("lhu100", 0, 3'b101, 64'h100, 64'h0000_789A, 1'b0, 3, 1, 64'h100, 64'h0, 0);
        do_load("lw100",  0, 3'b010, 64'h100, 64'h3456_789A, 1'b0, 3, 1, 64'h100, 64'h0, 0);
        // word-spanning accesses, including address wraparound
        do_load("lw102",  0, 3'b010, 64'h102, 64'hBEEF_3456, 1'b0, 5, 2, 64'h100, 64'h104, 0);
        do_load("lh103",  0, 3'b001, 64'h103, 64'hFFFF_EF34, 1'b0, 5, 2, 64'h100, 64'h104, 0);
        do_load("lhu103", 0, 3'b101, 64'h103, 64'h0000_EF34, 1'b0, 5, 2, 64'h100, 64'h104, 0);
        do_load("lwwrap", 0, 3'b010, 64'hFFFF_FFFE, 64'h7788_1122, 1'b0, 5, 2, 64'hFFFF_FFFC, 64'h0, 0);
        // illegal funct3 on 32-bit
        do_load("ld32",   0, 3'b011, 64'h100, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0, 0);
        do_load("lwu32",  0, 3'b110, 64'h100, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0, 0);
        // backpressure on each memory request
        do_load("lw102s", 0, 3'b010, 64'h102, 64'hBEEF_3456, 1'b0, 11, 2, 64'h100, 64'h104, 3);
        do_load("lb100s", 0, 3'b000, 64'h100, 64'hFFFF_FF9A, 1'b0, 6, 1, 64'h100, 64'h0, 3);
        watch_no_rsp("stray", 0, 5);
        chk("stray.hold", f_rd(0), 64'hFFFF_FF9A);

        // misaligned support disabled
        do_load("nm.lw102", 1, 3'b010, 64'h102, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0, 0);
        do_load("nm.f111",  1, 3'b111, 64'h55, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0, 0);
        do_load("nm.lh102", 1, 3'b001, 64'h102, 64'h0000_3456, 1'b0, 3, 1, 64'h100, 64'h0, 0);
        do_load("nm.lw100", 1, 3'b010, 64'h100, 64'h3456_789A, 1'b0, 3, 1, 64'h100, 64'h0, 0);

        // 64-bit datapath
        do_load("ld0",   2, 3'b011, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1, 64'h0, 64'h0, 0);
        do_load("lw0",   2, 3'b010, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 3, 1, 64'h0, 64'h0, 0);
        do_load("lwu4",  2, 3'b110, 64'h4, 64'h0000_0000_0123_4567, 1'b0, 3, 1, 64'h0, 64'h0, 0);
        do_load("lb7",   2, 3'b000, 64'h7, 64'h0000_0000_0000_0001, 1'b0, 3, 1, 64'h0, 64'h0, 0);
        do_load("ld4",   2, 3'b011, 64'h4, 64'h7654_3210_0123_4567, 1'b0, 5, 2, 64'h0, 64'h8, 0);
        do_load("f111",  2, 3'b111, 64'h10, 64'h0, 1'b1, 1, 0, 64'h0, 64'h0, 0);

        // reset while waiting for the first response
        auto_en[0] = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b1;
        f3[0]        = 3'b010;
        req_addr[0]  = 64'h100;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        watch_no_rsp("rstmid", 0, 5);
        chk("rstmid.ready", 64'(rr[0]), 64'd1);
        chk("rstmid.data", f_rd(0), 64'd0);
        chk("rstmid.fault", 64'(rf[0]), 64'd0);
        auto_en[0] = 1'b1;
        do_load("post.lw104", 0, 3'b010, 64'h104, 64'hDEAD_BEEF, 1'b0, 3, 1, 64'h104, 64'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential load unit between the LSU address stage and the data memory port.
- Issues word-aligned memory reads, extracts the addressed byte/half/word/double, and sign- or zero-extends it by funct3.
- A misaligned access that spans two memory words is split into two back-to-back reads and merged.
- Parametrised in XLEN (32/64). Misaligned support can be disabled, in which case the unit faults instead.

Parameters:
- XLEN, 32, datapath and address width; legal values 32 or 64.
- MISALIGNED_EN, 1, 1 = split spanning accesses into two reads; 0 = report fault, no memory access.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit idle, can accept a request.
- req_funct3  in  3  LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110.
- req_addr  in  XLEN  byte address.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  word-aligned read address (low log2(XLEN/8) bits zero).
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  XLEN  read data, little-endian.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_data  out  XLEN  extended load result.
- rsp_fault  out  1  qualifies rsp_valid: illegal funct3 or disallowed misaligned access.

Behaviour:
- Reset: state=IDLE. req_ready=1. mem_req_valid, rsp_valid and rsp_fault are 0; rsp_data=0; mem_req_addr=0. Reset mid-operation aborts the access; no rsp_valid is produced for it.
- Size: 1, 2, 4 or 8 bytes by funct3[1:0]. Offset = req_addr mod (XLEN/8). Base = req_addr with offset cleared.
- Illegal funct3: 111 always; 011 and 110 when XLEN=32.
- spans = (offset + size > XLEN/8).
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture funct3 and addr.
  - If illegal funct3, or spans with MISALIGNED_EN=0, go to DONE with fault.
  - Otherwise go to REQ0.
- REQ0: mem_req_valid=1, mem_req_addr=base. Hold both stable until mem_req_ready, then go to WAIT0.
- WAIT0: on mem_rsp_valid, capture lo word. If spans go to REQ1, else go to DONE.
- REQ1: mem_req_valid=1, mem_req_addr = base + XLEN/8, wrapping modulo 2^XLEN. Hold until mem_req_ready, then go to WAIT1.
- WAIT1: on mem_rsp_valid, capture hi word, then go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then return to IDLE.
- rsp_data and rsp_fault are registered and hold their value until the next DONE.
- Extraction:
  - Form {hi, lo} (2*XLEN bits; hi=0 if not spanning).
  - Shift right by offset*8 and keep the low size bytes.
  - Signed ops (funct3[2]=0) sign-extend from the top kept bit; unsigned ops zero-extend.
  - LD/LW at XLEN width are a pass-through.
- Fault case: rsp_data=0, rsp_fault=1, no mem_req_valid issued.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored. req_valid outside IDLE is ignored (req_ready=0).
- Latency (zero-wait memory, rsp in the cycle after the handshake):
  - Aligned: rsp_valid 3 cycles after the acceptance edge.
  - Spanning: 5 cycles.
  - Fault: 1 cycle.
- Each mem_req_ready stall cycle adds 1 cycle; each response wait cycle adds 1 cycle.

Test Plan:
- XLEN=32, word 0x100=0x3456789A, zero-wait memory:
  - LB @0x100 -> rsp_data=0xFFFFFF9A, rsp_valid 3 cycles after accept.
  - LBU @0x103 -> 0x00000034.
  - LH @0x102 -> 0x00003456.
  - LHU @0x100 -> 0x0000789A.
  - LW @0x100 -> 0x3456789A.
- Spanning, XLEN=32, 0x104=0xDEADBEEF:
  - LW @0x102 -> mem addrs 0x100 then 0x104, rsp_data=0xBEEF3456, 5-cycle latency.
  - LH @0x103 -> 0xFFFFEF34.
  - LHU @0x103 -> 0x0000EF34.
- MISALIGNED_EN=0: LW @0x102 -> no mem_req_valid, rsp_valid next cycle with rsp_fault=1, rsp_data=0. Same result for funct3=111 at any address.
- Backpressure: hold mem_req_ready low 3 cycles in REQ0 and REQ1 -> mem_req_addr stable and mem_req_valid held; result unchanged; latency +3 per stalled request. A stray mem_rsp_valid in IDLE produces no rsp_valid.
- XLEN=64, dword 0x0=0x0123456789ABCDEF:
  - LD @0 -> 0x0123456789ABCDEF.
  - LW @0 -> 0xFFFFFFFF89ABCDEF.
  - LWU @4 -> 0x0000000001234567.
  - funct3=011 with XLEN=32 -> fault.
- Reset: assert rst during WAIT0, then deliver mem_rsp_valid after release -> no rsp_valid, req_ready=1, rsp_data=0. The next request completes normally.
